harvard_bus_bridge: RTL
=======================

Name: harvard_bus_bridge

Overview:
Parametrised bridge that merges the CPU's separate instruction-fetch and data ports onto one Avalon-style memory bus with waitrequest. It arbitrates between the two requesters, holds bus signals stable across stalls and returns read data with a one-cycle done pulse. It sits between the CPU core and the single-port memory and is the path from the Harvard top level to the bus-based top level.

Parameters:
ADDR_W, 32, address width of requesters and bus
DATA_W, 32, data width; must be a multiple of 8
PRIO_DATA, 1, 1 = fixed priority (data over fetch); 0 = round-robin on last grant
MAX_WAIT, 255, waitrequest cycles before timeout (used only with BRIDGE_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
if_req  in  1  fetch request; level, held until if_done
if_addr  in  ADDR_W  fetch address
if_done  out  1  one-cycle pulse: fetch complete
if_rdata  out  DATA_W  fetch data; valid while if_done=1
d_req  in  1  data request; level, held until d_done
d_write  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_be  in  DATA_W/8  byte enables
d_done  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  read data; valid while d_done=1
address  out  ADDR_W  bus address
read  out  1  bus read strobe
write  out  1  bus write strobe
writedata  out  DATA_W  bus write data
byteenable  out  DATA_W/8  bus byte enables
waitrequest  in  1  bus stall
readdata  in  DATA_W  bus read data; valid when read=1 and waitrequest=0
timeout  out  1  sticky timeout flag (tied 0 without BRIDGE_TIMEOUT_EN)

Behaviour:
- Reset is asynchronous and active-low. While reset=0: state IDLE; read, write, if_done, d_done and timeout are 0; address, writedata, byteenable, if_rdata and d_rdata are 0; last_grant = fetch. An in-flight transaction is dropped and is not replayed.
- FSM states are IDLE, BUSY and RESP.
- IDLE: if either request is high, register the winner's address, write data, byte enables and strobe, and go to BUSY. Fetch accesses always drive byteenable all-ones and write=0. Bus signals go high in the cycle after the request is sampled.
- Arbitration with PRIO_DATA=1: d_req wins. With PRIO_DATA=0, on a simultaneous request the port that was not last_grant wins. last_grant updates on every grant.
- BUSY: all bus outputs are held constant. On a clock edge with waitrequest=0: deassert read/write, capture readdata (reads only) into the winner's rdata register, go to RESP.
- RESP: the winner's done is 1 for exactly this cycle; next state is IDLE. The requester must drop req or change it by the following edge, so a held req is re-granted as a new access.
- Minimum latency is 3 cycles from req to done when waitrequest=0 immediately. Each waitrequest cycle adds one.
- if_rdata and d_rdata hold their value until the next completion on that port.
- read and write are never both 1. No new grant is made while in BUSY or RESP.
- A request appearing during another port's BUSY waits. With PRIO_DATA=1, continuous d_req may starve fetch; this is intentional.

Optional Feature:
BRIDGE_TIMEOUT_EN. When defined, a counter increments each BUSY cycle with waitrequest=1 and clears on entering BUSY. When the count reaches MAX_WAIT: set timeout (sticky until reset), abort the access (strobes go to 0), pulse the winner's done with rdata = 0, and return to IDLE through RESP. When not defined: no counter, timeout is tied to 0, and BUSY waits indefinitely.

Decomposition:
- Package bridge_pkg holds the state enum (IDLE, BUSY, RESP) and the grant enum (GRANT_IF, GRANT_D).
- One sub-module, bridge_arbiter: combinational winner selection from if_req, d_req, last_grant and PRIO_DATA.
- FSM, bus registers and timeout counter stay in the top.

Test Plan:
- Fetch read, waitrequest=0: if_req=1, if_addr=0xBFC00000, readdata=0x24020005 -> read=1 for 1 cycle; if_done at cycle 3; if_rdata=0x24020005.
- Data write with 2 wait cycles: d_write=1, d_addr=0x1000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> write, address, writedata and byteenable stable for 3 cycles; d_done at cycle 5.
- Simultaneous requests, PRIO_DATA=1: data served first, fetch next. PRIO_DATA=0 with last_grant=fetch: data first; repeat -> the grant alternates.
- Reset mid-BUSY: assert reset=0 during waitrequest=1 -> read/write drop to 0 immediately; no done pulse; after release, IDLE with no bus activity.
- Back-to-back reads: d_req held across d_done -> second access starts the cycle after RESP; d_rdata updates only on the second done.
- With BRIDGE_TIMEOUT_EN and MAX_WAIT=4, waitrequest stuck at 1 -> strobes drop after 4 stall cycles; timeout=1 stays set; d_done pulses with d_rdata=0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types for the Harvard-to-Avalon bus bridge.
//   state_t : bridge FSM states (IDLE, BUSY, RESP)
//   grant_t : which requester owns the bus (fetch or data port)
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_t;

endpackage

// File: rtl/bridge_arbiter.sv
// Combinational winner selection between the fetch and data requesters.
// Ports:
//   if_req, d_req : request levels from the two CPU ports
//   last_grant    : port granted most recently (used for round-robin)
//   any_req       : at least one request is pending
//   winner        : port that gets the bus if a grant is made this cycle
// PRIO_DATA=1 gives the data port fixed priority; PRIO_DATA=0 alternates on
// simultaneous requests, favouring the port that was not granted last.
module bridge_arbiter
  import bridge_pkg::*;
#(
  parameter int PRIO_DATA = 1
) (
  input  logic   if_req,
  input  logic   d_req,
  input  grant_t last_grant,
  output logic   any_req,
  output grant_t winner
);

  always_comb begin
    any_req = if_req | d_req;
    winner  = GRANT_IF;
    if (d_req && !if_req) begin
      winner = GRANT_D;
    end else if (d_req && if_req) begin
      if (PRIO_DATA != 0) begin
        winner = GRANT_D;
      end else if (last_grant == GRANT_IF) begin
        winner = GRANT_D;
      end else begin
        winner = GRANT_IF;
      end
    end
  end

endmodule

// File: rtl/harvard_bus_bridge.sv
// Merges the CPU instruction-fetch port and data port onto one Avalon-style
// memory bus with waitrequest.
// Ports:
//   clk, reset (async, active-low)
//   fetch port : if_req, if_addr -> if_done, if_rdata
//   data port  : d_req, d_write, d_addr, d_wdata, d_be -> d_done, d_rdata
//   bus        : address, read, write, writedata, byteenable <- waitrequest, readdata
//   timeout    : sticky stall-timeout flag
//   state_dbg  : current FSM state, for observation only
// Handshakes: a requester holds req (and its address/data) at a level until
// its done pulses for one cycle; a bus transfer is offered while read or write
// is 1 and is accepted on the clock edge where waitrequest is 0.
// Optional feature macro: BRIDGE_TIMEOUT_EN aborts an access after MAX_WAIT
// stalled cycles; without it timeout is tied to 0 and stalls wait forever.
module harvard_bus_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_DATA = 1,
  parameter int MAX_WAIT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  output logic                timeout,
  output state_t              state_dbg
);

  if (((DATA_W % 8) != 0) || (MAX_WAIT < 1)) begin : g_param_check
    $error("harvard_bus_bridge: DATA_W must be a multiple of 8 and MAX_WAIT >= 1");
  end

  state_t state;
  grant_t last_grant;
  grant_t owner;      // port that owns the access currently on the bus
  grant_t winner;
  logic   any_req;

  bridge_arbiter #(.PRIO_DATA(PRIO_DATA)) u_arbiter (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  assign state_dbg = state;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             stall_limit;
  // The edge that would bring the stall count to MAX_WAIT aborts instead.
  assign stall_limit = (wait_cnt == CNT_W'(MAX_WAIT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= GRANT_IF;
      owner      <= GRANT_IF;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      wait_cnt   <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= BUSY;
            owner      <= winner;
            last_grant <= winner;
`ifdef BRIDGE_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
            if (winner == GRANT_D) begin
              address    <= d_addr;
              writedata  <= d_wdata;
              byteenable <= d_be;
              read       <= ~d_write;
              write      <= d_write;
            end else begin
              // Fetches are always full-width reads.
              address    <= if_addr;
              writedata  <= '0;
              byteenable <= '1;
              read       <= 1'b1;
              write      <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            state <= RESP;
            if (owner == GRANT_D) begin
              d_done <= 1'b1;
              if (read) d_rdata <= readdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= readdata;
            end
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (stall_limit) begin
            read    <= 1'b0;
            write   <= 1'b0;
            state   <= RESP;
            timeout <= 1'b1;
            if (owner == GRANT_D) begin
              d_done  <= 1'b1;
              d_rdata <= '0;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        // Done pulses here; requests are not sampled on this edge.
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
